// File: rtl/fetch_instr_buffer.sv
// Circular instruction buffer between fetch and the 2-wide decode stage.
// Up to FETCH_W packets in per cycle; the oldest two are presented to decode.

module fetch_instr_buffer_chk #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 4
) (
    input logic                           clk,
    input logic                           rst,
    input logic [$clog2(FETCH_W+1)-1:0]   in_cnt,
    input logic [$clog2(DEPTH)-1:0]       head,
    input logic [$clog2(DEPTH)-1:0]       tail,
    input logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IN_W  = $clog2(FETCH_W+1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [IN_W-1:0]  FETCH_IN_C = IN_W'(FETCH_W);

    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);

    // A full buffer has tail == head, so comparing modulo DEPTH covers both cases.
    a_ptr_match: assert property (@(posedge clk) disable iff (rst)
        count[PTR_W-1:0] == PTR_W'(tail - head));

    a_in_cnt_legal: assert property (@(posedge clk) disable iff (rst) in_cnt <= FETCH_IN_C);
endmodule

module fetch_instr_buffer #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 4,
    parameter int DATA_W  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [$clog2(FETCH_W+1)-1:0]   in_cnt,
    input  logic [FETCH_W*DATA_W-1:0]      in_data,
    output logic                           in_ready,
    output logic [1:0]                     out_valid,
    output logic [2*DATA_W-1:0]            out_data,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IN_W  = $clog2(FETCH_W+1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FETCH_C    = CNT_W'(FETCH_W);
    localparam logic [IN_W-1:0]  FETCH_IN_C = IN_W'(FETCH_W);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic [CNT_W-1:0]  free_s;
    logic              in_ready_s;
    logic [IN_W-1:0]   in_clamp_s;
    logic [IN_W-1:0]   enq_num_s;
    logic [1:0]        out_valid_s;
    logic [1:0]        deq_num_s;
    logic [PTR_W-1:0]  rd1_idx_s;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    // Credit and valid flags depend only on registered occupancy.
    always_comb begin
        free_s         = DEPTH_C - count_r;
        in_ready_s     = (free_s >= FETCH_C);
        out_valid_s[0] = (count_r >= CNT_W'(1));
        out_valid_s[1] = (count_r >= CNT_W'(2));
        rd1_idx_s      = head_r + PTR_W'(1);
    end

    // Enqueue/dequeue amounts; flush suppresses both.
    always_comb begin
        in_clamp_s = in_cnt;
        enq_num_s  = {IN_W{1'b0}};
        deq_num_s  = 2'd0;
        if (in_cnt > FETCH_IN_C) begin
            in_clamp_s = FETCH_IN_C;
        end else begin
            in_clamp_s = in_cnt;
        end
        if (in_ready_s && !flush) begin
            enq_num_s = in_clamp_s;
        end else begin
            enq_num_s = {IN_W{1'b0}};
        end
        if (out_ready && !flush) begin
            deq_num_s = popcount2(out_valid_s);
        end else begin
            deq_num_s = 2'd0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            head_r  <= head_r + PTR_W'(deq_num_s);
            tail_r  <= tail_r + PTR_W'(enq_num_s);
            count_r <= count_r + CNT_W'(enq_num_s) - CNT_W'(deq_num_s);
        end
    end

    // Packet storage; lanes wrap naturally through the power-of-2 index.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (IN_W'(k) < enq_num_s) begin
                mem_r[tail_r + PTR_W'(k)] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = {mem_r[rd1_idx_s], mem_r[head_r]};
    assign count     = count_r;

    fetch_instr_buffer_chk #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .in_cnt (in_cnt),
        .head   (head_r),
        .tail   (tail_r),
        .count  (count_r)
    );
endmodule

// File: tb/tb_fetch_instr_buffer.sv
// Directed bench for fetch_instr_buffer: hand-computed checks plus a packet queue model.
module tb_fetch_instr_buffer;
    localparam int DEPTH   = 16;
    localparam int FETCH_W = 4;
    localparam int DATA_W  = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   in_cnt = 3'd0;
    logic [FETCH_W*DATA_W-1:0] in_data = '0;
    logic         in_ready;
    logic [1:0]   out_valid;
    logic [2*DATA_W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [4:0]   count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] q[$];

    fetch_instr_buffer #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_cnt(in_cnt), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_0000};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic check_state();
        check("count", 64'(count), 64'(q.size()));
        check("out_valid", 64'(out_valid), {62'd0, q.size() >= 2, q.size() >= 1});
        if (q.size() >= 1) check("lane0", out_data[63:0], q[0]);
        if (q.size() >= 2) check("lane1", out_data[127:64], q[1]);
    endtask

    // One clock: drive inputs, step the model across the edge, compare.
    task automatic cycle(input int n, input logic [31:0] base, input logic rdy, input logic fl);
        logic rdy_model;
        int   ndeq;
        in_cnt    = 3'(n);
        out_ready = rdy;
        flush     = fl;
        for (int k = 0; k < FETCH_W; k++) in_data[k*DATA_W +: DATA_W] = mk(base + 32'(4*k));
        #1;
        rdy_model = ((DEPTH - q.size()) >= FETCH_W);
        check("in_ready", {63'd0, in_ready}, {63'd0, rdy_model});
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            ndeq = rdy ? ((q.size() >= 2) ? 2 : q.size()) : 0;
            for (int i = 0; i < ndeq; i++) void'(q.pop_front());
            if (rdy_model) for (int k = 0; k < n; k++) q.push_back(mk(base + 32'(4*k)));
        end
        #1;
        in_cnt = 3'd0; out_ready = 1'b0; flush = 1'b0;
        check_state();
    endtask

    initial begin
        int n;
        logic r;
        logic [31:0] pc;

        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_async_count", 64'(count), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        repeat (5) cycle(0, 32'h0, 1'b0, 1'b0);
        check("idle_count", 64'(count), 64'd0);

        cycle(3, 32'h1000, 1'b0, 1'b0);
        check("enq3_count", 64'(count), 64'd3);
        check("enq3_valid", 64'(out_valid), 64'd3);
        check("enq3_lane0", out_data[63:0], mk(32'h1000));
        check("enq3_lane1", out_data[127:64], mk(32'h1004));
        cycle(0, 32'h0, 1'b1, 1'b0);
        check("deq2_count", 64'(count), 64'd1);
        check("deq2_lane0", out_data[63:0], mk(32'h1008));
        check("deq2_valid", 64'(out_valid), 64'd1);
        cycle(0, 32'h0, 1'b1, 1'b0);
        check("empty_count", 64'(count), 64'd0);

        for (int i = 0; i < 4; i++) begin
            cycle(4, 32'h2000 + 32'(16*i), 1'b0, 1'b0);
            check("fill_count", 64'(count), 64'(4*(i+1)));
        end
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        cycle(4, 32'h2040, 1'b0, 1'b0);
        check("held_count16", 64'(count), 64'd16);
        cycle(4, 32'h2040, 1'b1, 1'b0);
        check("held_count14", 64'(count), 64'd14);
        check("held_in_ready14", {63'd0, in_ready}, 64'd0);
        cycle(4, 32'h2040, 1'b1, 1'b0);
        check("held_count12", 64'(count), 64'd12);
        check("held_in_ready12", {63'd0, in_ready}, 64'd1);
        cycle(4, 32'h2040, 1'b1, 1'b0);
        check("held_admit_count", 64'(count), 64'd14);
        check("held_admit_lane0", out_data[63:0], mk(32'h2018));
        for (int i = 0; i < 7; i++) cycle(0, 32'h0, 1'b1, 1'b0);

        cycle(4, 32'h2800, 1'b0, 1'b0);
        cycle(3, 32'h2810, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1'b1, 1'b0);
        cycle(1, 32'h3000, 1'b0, 1'b0);
        check("wrap_a_lane0", out_data[63:0], mk(32'h3000));
        cycle(3, 32'h3004, 1'b1, 1'b0);
        check("wrap_count", 64'(count), 64'd3);
        check("wrap_b_lane0", out_data[63:0], mk(32'h3004));
        check("wrap_c_lane1", out_data[127:64], mk(32'h3008));
        cycle(0, 32'h0, 1'b1, 1'b0);
        check("wrap_d_lane0", out_data[63:0], mk(32'h300C));
        check("wrap_d_valid", 64'(out_valid), 64'd1);
        cycle(0, 32'h0, 1'b1, 1'b0);

        cycle(4, 32'h4000, 1'b0, 1'b0);
        cycle(1, 32'h4010, 1'b0, 1'b0);
        check("sim_count5", 64'(count), 64'd5);
        cycle(4, 32'h4014, 1'b1, 1'b0);
        check("sim_count7", 64'(count), 64'd7);
        check("sim_lane0", out_data[63:0], mk(32'h4008));
        pc = 32'h4024;
        repeat (10) begin
            n = $urandom_range(0, 4);
            r = 1'($urandom_range(0, 1));
            cycle(n, pc, r, 1'b0);
            pc = pc + 32'(4*n);
        end
        for (int i = 0; i < 12 && q.size() > 0; i++) cycle(0, 32'h0, 1'b1, 1'b0);
        check("drained_count", 64'(count), 64'd0);

        cycle(4, 32'h5000, 1'b0, 1'b0);
        cycle(4, 32'h5010, 1'b0, 1'b0);
        cycle(1, 32'h5020, 1'b0, 1'b0);
        check("pre_flush_count", 64'(count), 64'd9);
        check("flush_cycle_valid", 64'(out_valid), 64'd3);
        cycle(4, 32'h6000, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        cycle(2, 32'h7000, 1'b0, 1'b0);
        check("post_flush_lane0", out_data[63:0], mk(32'h7000));
        check("post_flush_count", 64'(count), 64'd2);

        #3 rst = 1'b1;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1, 32'h8000, 1'b0, 1'b0);
        check("post_rst_lane0", out_data[63:0], mk(32'h8000));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_instr_buffer.md
Name: fetch_instr_buffer

Overview:
- Circular FIFO between fetch and decode.
- Accepts up to FETCH_W fetched instruction packets per cycle and presents the oldest two to decode as a 2-wide group.
- The valid/allowin pair on the decode side is what drives the issue queue's valid_D[1:0] / allowin_I handshake one stage later.
- Flush on branch mispredict/exception discards all buffered packets.

Parameters:
- DEPTH, 16, number of packet entries; power of 2, >= 2*FETCH_W.
- FETCH_W, 4, max packets enqueued per cycle.
- DATA_W, 64, packet width ({pc[31:0], instr[31:0]}).

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all contents.
- in_cnt  input  $clog2(FETCH_W+1)  packets offered this cycle, lanes 0..in_cnt-1.
- in_data  input  FETCH_W*DATA_W  lane k at bits [k*DATA_W +: DATA_W]; lane 0 oldest.
- in_ready  output  1  allowin_F; buffer can take a full fetch group.
- out_valid  output  2  out_valid[0]: >=1 packet; out_valid[1]: >=2 packets.
- out_data  output  2*DATA_W  lane 0 = oldest entry (head), lane 1 = head+1.
- out_ready  input  1  downstream allowin; consumes all asserted out_valid lanes.
- count  output  $clog2(DEPTH+1)  current occupancy (debug/perf).

Behaviour:
- State: mem[DEPTH], head, tail (each $clog2(DEPTH) bits, natural wrap modulo DEPTH), count ($clog2(DEPTH+1) bits).
- Reset (async, rst=1):
  - head=tail=count=0 immediately.
  - Outputs: in_ready=1, out_valid=2'b00, count=0.
  - out_data don't-care but must not be X-propagating into valid.
- in_ready = (DEPTH - count >= FETCH_W). Combinational from registered count only. No dependence on out_ready: no same-cycle free-slot credit.
- enq_num = (in_ready && !flush) ? min(in_cnt, FETCH_W) : 0. in_cnt > FETCH_W is illegal; RTL clamps to FETCH_W, assertion flags it.
- out_valid[0] = (count >= 1); out_valid[1] = (count >= 2). Pure function of registered state; no combinational in->out bypass.
- Minimum latency: a packet written at edge N appears on out_data at cycle N+1.
- out_data lane 0 = mem[head]; lane 1 = mem[(head+1) mod DEPTH]. Lane 1 is don't-care when out_valid[1]=0.
- deq_num = (out_ready && !flush) ? popcount(out_valid) : 0.
- Update on posedge when not flush:
  - Write lane k to mem[(tail+k) mod DEPTH] for k < enq_num.
  - tail += enq_num; head += deq_num; count += enq_num - deq_num.
- Simultaneous enqueue and dequeue in the same cycle are legal and fully independent.
- Wrap-around: a fetch group straddling index DEPTH-1 -> 0 splits correctly. The lane-1 read at head=DEPTH-1 uses mem[0].
- Full: count=DEPTH-FETCH_W+1 or higher drops in_ready. Upstream must hold its group; nothing is written.
- Empty: out_valid=00; out_ready is ignored and head does not move.
- Flush (synchronous, priority over enqueue/dequeue):
  - Next edge: head=tail=count=0.
  - The flush-cycle in_data is discarded; out_valid is still shown that cycle but is not consumed.
  - mem contents need not be cleared.
- rst asserted mid-operation: state is cleared asynchronously regardless of clk/flush. Deassertion is synchronized externally.
- Invariant (assertion): count never exceeds DEPTH; count == (tail-head) mod DEPTH, except count==DEPTH with tail==head.

Test Plan:
- Reset then idle:
  - rst=1 mid-cycle -> out_valid=00, in_ready=1, count=0 without waiting for a clock edge.
  - rst=0, in_cnt=0 for 5 cycles -> no change.
- Single enqueue/dequeue:
  - in_cnt=3, pc 0x1000/0x1004/0x1008, out_ready=0 -> next cycle count=3, out_valid=11, out_data lanes = 0x1000, 0x1004.
  - Then out_ready=1 -> count=1, lane0=0x1008, out_valid=01.
- Fill to backpressure:
  - in_cnt=4 every cycle, out_ready=0 -> in_ready drops once count=16.
  - Further groups are not written; the held group enters only after draining leaves >=4 free entries.
- Wrap-around:
  - Pre-advance head=tail=14 via enqueue/dequeue, then in_cnt=4 (pcs A..D) -> entries land at 14, 15, 0, 1.
  - Dequeue order is A, B, C, D; lane1 at head=15 reads entry 0.
- Simultaneous traffic:
  - count=5, in_cnt=4, out_ready=1 -> next count=7; order preserved across 10 cycles of random in_cnt vs a scoreboard.
- Flush:
  - count=9, flush=1 together with in_cnt=4 and out_ready=1 -> next cycle count=0, out_valid=00, in_ready=1.
  - The first post-flush group appears at lane 0.
